// File: rtl/pipe_adder_pkg.sv
// Shared constants and payload layout for the carry-pipelined adder.
package pipe_adder_pkg;

    localparam int PA_WIDTH  = 32;
    localparam int PA_STAGES = 4;

    // Payload carried between stages in the default configuration.
    typedef struct packed {
        logic [PA_WIDTH-1:0] psum;
        logic                carry;
        logic [PA_WIDTH-1:0] opa;
        logic [PA_WIDTH-1:0] opb;
        logic                valid;
    } stage_t;

    function automatic bit cfg_ok(input int w, input int s);
        return (s >= 1) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CW-bit ripple-carry adder, one per pipeline stage.
module adder_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    logic [CW:0] cy;

    always_comb begin
        cy    = '0;
        s     = '0;
        cy[0] = ci;
        for (int i = 0; i < CW; i++) begin
            s[i]    = a[i] ^ b[i] ^ cy[i];
            cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
    end

    assign co = cy[CW];

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder with per-stage valid and ready/valid handshake.
// Optional signed-overflow output enabled by macro PIPE_ADDER_OVF_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = PA_WIDTH,
    parameter int STAGES = PA_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] psum;
        logic             carry;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
    } pay_t;

    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] vld_in;
    logic [STAGES:0]   rdy;

    // rdy[k]: stage k may load this cycle (empty, or its content moves on).
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = !vld_pipe[k] || rdy[k+1];
    end

    always_comb begin
        vld_in    = '0;
        vld_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++)
            vld_in[k] = vld_pipe[k-1];
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe <= (vld_pipe & ~rdy[STAGES-1:0]) | (vld_in & rdy[STAGES-1:0]);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        pay_t          src;
        pay_t          nxt;
        pay_t          stg;
        logic [CW-1:0] s;
        logic          co;

        if (k == 0) begin : g_first
            assign src = '{psum: '0, carry: cin, opa: a, opb: b};
        end else begin : g_next
            assign src = g_stg[k-1].stg;
        end

        adder_slice #(.CW(CW)) u_slice (
            .a  (src.opa[k*CW +: CW]),
            .b  (src.opb[k*CW +: CW]),
            .ci (src.carry),
            .s  (s),
            .co (co)
        );

        always_comb begin
            nxt                   = src;
            nxt.psum[k*CW +: CW]  = s;
            nxt.carry             = co;
        end

        // Datapath is not reset; outputs are masked by the valid bit instead.
        always_ff @(posedge clk) begin
            if (rdy[k])
                stg <= nxt;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[STAGES-1];
    assign sum       = out_valid ? g_stg[STAGES-1].stg.psum : '0;
    assign cout      = out_valid & g_stg[STAGES-1].stg.carry;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_nxt;
    logic ovf_q;

    // Carry into the MSB is a^b^s at that bit; overflow is that XOR carry-out.
    assign ovf_nxt = g_stg[STAGES-1].src.opa[WIDTH-1] ^ g_stg[STAGES-1].src.opb[WIDTH-1]
                   ^ g_stg[STAGES-1].s[CW-1] ^ g_stg[STAGES-1].co;

    always_ff @(posedge clk) begin
        if (rdy[STAGES-1])
            ovf_q <= ovf_nxt;
    end

    assign ovf = out_valid & ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Randomized scoreboard bench for pipe_adder (WIDTH=32, STAGES=4).
module tb_pipe_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
`endif

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ret  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: full-precision add, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
        logic [W:0] r;
        logic       v;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {v, r};
    endfunction

    logic [W+1:0] q[$];
    logic         hold_v = 1'b0;
    logic [W+1:0] hold_d;

    // Scoreboard: retire before accept, since retire pops the oldest entry.
    always @(negedge clk) begin
        logic [W+1:0] e;
        logic [W+1:0] obs;
        obs = {1'b0, cout, sum};
`ifdef PIPE_ADDER_OVF_EN
        obs[W+1] = ovf;
`endif
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold", {out_valid, obs}, {1'b1, hold_d});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e[W-1:0]);
                    chk("cout", cout, e[W]);
`ifdef PIPE_ADDER_OVF_EN
                    chk("ovf", ovf, e[W+1]);
`endif
                    n_ret++;
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = obs;
            if (in_valid && in_ready)
                q.push_back(model(a, b, cin));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_in();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic [W-1:0] es, input logic ec, input string tag);
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= S; i++) begin
            @(negedge clk);
            if (i == S - 1)
                chk({tag, "_early"}, out_valid, 0);
            if (i == S) begin
                chk({tag, "_vld"}, out_valid, 1);
                chk({tag, "_sum"}, sum, es);
                chk({tag, "_cout"}, cout, ec);
            end
            tick();
        end
    endtask

    initial begin
        int acc;
        int cnt;
        int r0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        tick();

        out_ready = 1'b1;
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "ripple1");
        directed(32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, "ripple2");

        // Back-to-back streaming.
        r0 = n_ret; cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rnd_in();
            @(negedge clk);
            if (!in_ready) cnt++;
            tick();
        end
        chk("stream_stalls", cnt, 0);
        chk("stream_rate", n_ret - r0, 1000 - S);
        in_valid = 1'b0;
        repeat (S + 4) tick();
        chk("stream_drain", q.size(), 0);
        chk("stream_total", n_ret - r0, 1000);

        // Backpressure: fill, hold, then release with a simultaneous accept.
        r0 = n_ret; acc = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2 * S; i++) begin
            rnd_in();
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        chk("bp_accepts", acc, S);
        rnd_in();
        @(negedge clk);
        chk("bp_full_rdy", in_ready, 0);
        chk("bp_full_vld", out_valid, 1);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_acc", in_ready, 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            rnd_in();
            tick();
        end
        in_valid = 1'b0;
        repeat (S + 4) tick();
        chk("bp_drain", q.size(), 0);
        chk("bp_total", n_ret - r0, S + 1 + 20);

        // Mid-flight reset discards in-flight work.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_in();
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
            tick();
        end
        chk("mrst_quiet", cnt, 0);
        r0 = n_ret;
        rnd_in(); in_valid = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (S + 2) tick();
        chk("mrst_after", n_ret - r0, 1);
        chk("mrst_drain", q.size(), 0);

`ifdef PIPE_ADDER_OVF_EN
        r0 = n_ret;
        in_valid = 1'b1;
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0; tick();
        a = 32'h8000_0000; b = 32'hFFFF_FFFF; cin = 1'b0; tick();
        a = 32'h0000_0005; b = 32'h0000_0003; cin = 1'b0; tick();
        in_valid = 1'b0;
        repeat (S + 2) tick();
        chk("ovf_total", n_ret - r0, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; slice width CW = WIDTH/STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input operands are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.

Function
REQ-013 A transfer SHALL occur on a cycle where in_valid and in_ready are both 1; results SHALL retire on out_valid && out_ready.
REQ-014 Stage k (0..STAGES-1) SHALL add bits [k*CW +: CW] of a and b plus the carry registered by stage k-1 (cin for stage 0), then register the partial sum, the carry-out and the not-yet-added upper operand bits.
REQ-015 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when there is no backpressure; throughput SHALL be one result per cycle.
REQ-016 Each stage SHALL hold its own valid bit; a stage SHALL load when it is empty or its downstream stage advances in the same cycle (bubble collapsing).
REQ-017 in_ready SHALL equal (stage 0 empty) OR (stage 0 advances this cycle); it SHALL NOT depend combinationally on in_valid.
REQ-018 While out_valid=1 and out_ready=0, sum, cout and out_valid SHALL hold stable; no accepted transaction SHALL be lost or duplicated.
REQ-019 Results SHALL emerge in acceptance order.
REQ-020 When the pipeline is full and out_ready=0, at most STAGES transactions SHALL be in flight and in_ready SHALL be 0.
REQ-021 When the pipe is full, a simultaneous retire and accept SHALL both succeed in the same cycle.
REQ-022 Operand values SHALL be ignored when in_valid=0; the datapath registers of empty stages MAY hold stale data.

Reset
REQ-023 When rst=1 at a clock edge, all stage valid bits SHALL clear, so out_valid=0 the following cycle.
REQ-024 The datapath registers SHALL NOT require reset; after reset, sum and cout SHALL read 0 until the first result, and in_ready SHALL be 1.
REQ-025 A reset during operation SHALL discard all in-flight transactions; none SHALL appear at the output afterwards.

Configuration
REQ-026 With macro PIPE_ADDER_OVF_EN defined, the block SHALL add output port ovf, 1 bit: two's-complement signed overflow (carry into MSB XOR cout); ovf SHALL be aligned with sum, held under stall, and 0 after reset.
REQ-027 Without PIPE_ADDER_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package pipe_adder_pkg SHALL hold the default WIDTH and STAGES constants and a stage-payload struct typedef (partial sum, carry, residual operands, valid).
REQ-029 Sub-module adder_slice SHALL be a combinational CW-bit ripple adder (a, b, ci -> s, co), instantiated once per stage with a generate loop.
REQ-030 An elaboration-time check SHALL fail the build when WIDTH % STAGES != 0 or when STAGES < 1.

Verification (WIDTH=32, STAGES=4)
REQ-031 Reset: hold rst for 2 cycles then release -> out_valid=0, in_ready=1, sum=0, cout=0.
REQ-032 Carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> exactly 4 cycles later sum=0x00000000, cout=1; a=0x0000FFFF, b=0, cin=1 -> sum=0x00010000, cout=0.
REQ-033 Streaming: 1000 random back-to-back transfers with out_ready=1 -> one result per cycle, in order, each matching the 33-bit reference sum.
REQ-034 Backpressure: out_ready=0 with in_valid=1 continuously -> exactly 4 transfers accepted, then in_ready=0 and outputs stable; out_ready=1 -> 4 results in order, followed by streaming with no loss.
REQ-035 Mid-flight reset: accept 3 transfers, assert rst for 1 cycle -> out_valid never rises for those 3 transfers; the next transfer completes normally.
REQ-036 With PIPE_ADDER_OVF_EN: a=0x7FFFFFFF, b=1 -> ovf=1; a=0x80000000, b=0xFFFFFFFF -> ovf=1, cout=1; a=5, b=3 -> ovf=0.
